fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/fetch_queue.sv | 75 +++++++
 rtl/fetch_stage.sv | 84 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-wide widths and constants, plus the fetch queue entry layout.
package cpu_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned ENTRY_W = ADDR_W + WORD_W;

  localparam logic [ADDR_W-1:0] PC_INC = 16'd2;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 16'h0000;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

  // Sequential fetch address; wraps naturally at the top of the address space.
  function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO of {pc, instr} entries between fetch and decode.
module fetch_queue import cpu_pkg::*; #(
  parameter int unsigned Depth = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               flush_i,
  input  logic [ENTRY_W-1:0] data_i,
  output logic [2:0]         count_o,
  output logic [ENTRY_W-1:0] head_o
);

  localparam int unsigned MaxDepth = 4;

  logic [ENTRY_W-1:0] mem_q [MaxDepth];
  logic [ENTRY_W-1:0] mem_d [MaxDepth];
  logic [1:0]         rd_ptr_q, rd_ptr_d;
  logic [1:0]         wr_ptr_q, wr_ptr_d;
  logic [2:0]         count_q, count_d;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(Depth - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop_i) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 3'd1;
        2'b01:   count_d = count_q - 3'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MaxDepth; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Issue throttling upstream must keep a push into a full queue impossible.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   (push_i && !pop_i && !flush_i) |-> (count_q != 3'(Depth)));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: issues one-cycle-latency memory reads and buffers them for decode.
module fetch_stage import cpu_pkg::*; #(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned       QDEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd,
  input  logic [WORD_W-1:0] imem_data,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  output logic [WORD_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] rd_pc_q, rd_pc_d;
  logic              inflight_q, inflight_d;
  logic              kill_q, kill_d;

  logic [2:0]         count;
  logic [ENTRY_W-1:0] head;
  fetch_entry_t       head_entry;
  logic               pop;
  logic               push;
  logic [3:0]         occupancy;

  assign pop       = if_valid & ~stall;
  // Entries already queued plus the one in flight, minus the one leaving this cycle.
  assign occupancy = {1'b0, count} + {3'b000, inflight_q} - {3'b000, pop};
  assign imem_rd   = rst & ~redirect & (occupancy < 4'(QDEPTH));
  assign imem_addr = pc_q;
  assign push      = inflight_q & ~kill_q & ~redirect;

  always_comb begin
    pc_d       = pc_q;
    rd_pc_d    = rd_pc_q;
    inflight_d = imem_rd;
    kill_d     = redirect;
    if (redirect) begin
      pc_d = {redirect_pc[ADDR_W-1:1], 1'b0};
    end else if (imem_rd) begin
      pc_d    = pc_next(pc_q);
      rd_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      rd_pc_q    <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      rd_pc_q    <= rd_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

  fetch_queue #(
    .Depth (QDEPTH)
  ) u_queue (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .data_i  ({rd_pc_q, imem_data}),
    .count_o (count),
    .head_o  (head)
  );

  assign head_entry = fetch_entry_t'(head);
  assign if_valid   = (count != 3'd0);
  // Stale entries behind a flush are never exposed to decode.
  assign if_instr   = if_valid ? head_entry.instr : '0;
  assign if_pc      = if_valid ? head_entry.pc : '0;

endmodule
